alu_muldiv_sequencer: RTL
=========================

// Module: alu_muldiv_sequencer
// PURPOSE
//   Multi-cycle mult/div initiator for the shared 32-bit ALU. Drives alu_control/operands, consumes alu_result each cycle.
//   Iterative shift-add multiply (64-bit product) and restoring divide (quotient + remainder), using only ALU ADD/SUB.
//   Sits between decode/control and the ALU instance. The parent muxes ALU inputs to this block while busy=1.
// PARAMETERS
//   WIDTH    32   operand width; also the iteration count
//   CNT_W    6    step-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   start        in   1      request pulse; sampled only in IDLE
//   op_div       in   1      0 = multiply, 1 = divide; captured with start
//   op_signed    in   1      signed operation; used only with ALU_SEQ_SIGNED_EN
//   operand_a    in   WIDTH  multiplicand / dividend
//   operand_b    in   WIDTH  multiplier / divisor
//   busy         out  1      high from the cycle after an accepted start through the DONE cycle
//   done         out  1      one-cycle pulse; results valid
//   result_hi    out  WIDTH  product[2W-1:W] / remainder
//   result_lo    out  WIDTH  product[W-1:0] / quotient
//   div_by_zero  out  1      set with done when op_div=1 and divisor=0
//   alu_a        out  WIDTH  ALU operand a
//   alu_b        out  WIDTH  ALU operand b
//   alu_control  out  4      ALU opcode; only ALU_ADD and ALU_SUB are issued
//   alu_result   in   WIDTH  combinational ALU result, same cycle
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, div_by_zero=0, result_hi=result_lo=0, count=0.
//   Reset: alu_a=alu_b=0, alu_control=ALU_ADD. Reset overrides any in-flight op, and start is ignored that cycle.
//   IDLE: alu_control=ALU_ADD, alu_a=alu_b=0.
//   IDLE + start: capture operands, load count=WIDTH.
//     Multiply: go to MUL. Divide, divisor!=0: go to DIV. Divide, divisor==0: go to DONE.
//   Start while not IDLE: ignored; no queueing.
//   MUL, WIDTH cycles; regs {hi, lo=multiplier, mcand}:
//     alu_a=hi, alu_b=mcand, ADD. carry=(alu_result < hi), compared unsigned.
//     If lo[0]: {hi,lo} <= {carry, alu_result, lo} >> 1. Else: {hi,lo} <= {1'b0, hi, lo} >> 1.
//   DIV, WIDTH cycles; regs {rem=0, quo=dividend, dvs}:
//     r_sh={rem[W-2:0], quo[W-1]}, msb=rem[W-1]; alu_a=r_sh, alu_b=dvs, SUB.
//     If msb | (r_sh >= dvs): rem<=alu_result, bit=1. Else: rem<=r_sh, bit=0. quo<={quo[W-2:0], bit}.
//   Step count: count decrements each step; at count==1 go to DONE.
//   DONE, 1 cycle: done=1, busy=1, result regs updated.
//     Divide by zero: result_lo={WIDTH{1'b1}}, result_hi=dividend, div_by_zero=1.
//     Then go to IDLE. Results and div_by_zero hold until the next accepted start.
//   Latency: start accepted at edge 0.
//     Mult / div with divisor!=0: done high in cycle WIDTH+1 (33 at default).
//     Divide by zero: done high in cycle 1.
//   Back-to-back: start may be asserted the cycle after done; it is accepted since state=IDLE.
//   The ALU zero output is unused; all comparisons are unsigned.
// CONFIGURATION
//   ALU_SEQ_SIGNED_EN defined:
//     op_signed=1: start takes magnitudes of negative operands and records sign flags.
//     After the last step, a FIX state negates per flags: product by sign_a^sign_b; quotient by sign_a^sign_b; remainder by sign_a.
//     The 64-bit product negation is done locally. Adds 1 cycle of latency (done in cycle WIDTH+2).
//     Divide by zero with signed op: same results as unsigned, no FIX state.
//   ALU_SEQ_SIGNED_EN undefined: op_signed ignored, no FIX state, all ops unsigned.
// STRUCTURE
//   Shared package alu_pkg: ALU_AND/OR/ADD(4'b0010)/SUB(4'b0110)/NOR/SLT/... opcode localparams.
//   alu_pkg also holds the seq_state_t enum {IDLE, MUL, DIV, FIX, DONE}, shared with the control unit.
//   No sub-module: single FSM plus datapath regs. The ALU is instantiated by the parent, not inside this block.
// TESTING
//   mul 7 x 6 -> done at cycle 33, result_hi=0, result_lo=42, div_by_zero=0
//   mul 0xFFFFFFFF x 0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001 (carry path)
//   div 100 / 7 -> result_lo=14, result_hi=2; alu_control=4'b0110 on every DIV cycle
//   div 5 / 0 -> done at cycle 1, div_by_zero=1, result_lo=0xFFFFFFFF, result_hi=5; next div 9/3 clears flag, gives 3 rem 0
//   reset at MUL step 10; start pulsed mid-op -> busy=0, done never pulses; the mid-op start is ignored; fresh mul 3x3 -> 9
//   ALU_SEQ_SIGNED_EN: -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; done cycle 34

Source files
------------

// File: rtl/alu_pkg.sv
// ALU opcode constants and the sequencer state encoding, shared with the control unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle shift-add multiply / restoring divide driving the shared ALU with ADD/SUB only.
// Optional signed support is enabled by defining ALU_SEQ_SIGNED_EN.
module alu_muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;

    logic [WIDTH-1:0] alu_a_s, alu_b_s;
    logic [3:0]       alu_ctrl_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, r_sh_s;
    logic             carry_s, take_s;
    seq_state_t       last_state_s;

`ifdef ALU_SEQ_SIGNED_EN
    logic signed_q, sign_a_q, sign_b_q, is_div_q;
    logic sign_a_s, sign_b_s;

    assign sign_a_s     = op_signed & operand_a[WIDTH-1];
    assign sign_b_s     = op_signed & operand_b[WIDTH-1];
    assign a_mag_s      = sign_a_s ? -operand_a : operand_a;
    assign b_mag_s      = sign_b_s ? -operand_b : operand_b;
    assign last_state_s = signed_q ? FIX : DONE;

    // Capture sign flags of the accepted operation for the final correction step.
    always_ff @(posedge clk) begin
        if (reset) begin
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            signed_q <= op_signed;
            sign_a_q <= sign_a_s;
            sign_b_q <= sign_b_s;
            is_div_q <= op_div;
        end else begin
            signed_q <= signed_q;
            sign_a_q <= sign_a_q;
            sign_b_q <= sign_b_q;
            is_div_q <= is_div_q;
        end
    end
`else
    logic unused_signed_s;

    assign unused_signed_s = op_signed;
    assign a_mag_s         = operand_a;
    assign b_mag_s         = operand_b;
    assign last_state_s    = DONE;
`endif

    // Partial remainder shifted left by one, pulling in the next dividend bit.
    assign r_sh_s  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign carry_s = (alu_result < hi_q);
    assign take_s  = hi_q[WIDTH-1] | (r_sh_s >= opb_q);

    // Next-state, datapath update and ALU drive.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        dbz_d      = dbz_q;
        alu_a_s    = {WIDTH{1'b0}};
        alu_b_s    = {WIDTH{1'b0}};
        alu_ctrl_s = ALU_ADD;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = CNT_LOAD;
                    dbz_d   = 1'b0;
                    hi_d    = {WIDTH{1'b0}};
                    lo_d    = a_mag_s;
                    opb_d   = b_mag_s;
                    if (!op_div) begin
                        state_d = MUL;
                    end else if (operand_b == {WIDTH{1'b0}}) begin
                        // Results are latched on entry to DONE, so stage them now.
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        hi_d    = operand_a;
                        lo_d    = {WIDTH{1'b1}};
                    end else begin
                        state_d = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                alu_a_s = hi_q;
                alu_b_s = opb_q;
                if (lo_q[0]) begin
                    hi_d = {carry_s, alu_result[WIDTH-1:1]};
                    lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[WIDTH-1:1]};
                    lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                end
                count_d = count_q - CNT_ONE;
                state_d = (count_q == CNT_ONE) ? last_state_s : MUL;
            end
            DIV: begin
                alu_a_s    = r_sh_s;
                alu_b_s    = opb_q;
                alu_ctrl_s = ALU_SUB;
                hi_d       = take_s ? alu_result : r_sh_s;
                lo_d       = {lo_q[WIDTH-2:0], take_s};
                count_d    = count_q - CNT_ONE;
                state_d    = (count_q == CNT_ONE) ? last_state_s : DIV;
            end
            FIX: begin
`ifdef ALU_SEQ_SIGNED_EN
                if (is_div_q) begin
                    lo_d = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
                    hi_d = sign_a_q ? -hi_q : hi_q;
                end else begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
                end
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered status/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= {CNT_W{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_hi_q <= {WIDTH{1'b0}};
            res_lo_q <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            dbz_q   <= dbz_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (state_d == DONE) begin
                res_hi_q <= hi_d;
                res_lo_q <= lo_d;
            end else begin
                res_hi_q <= res_hi_q;
                res_lo_q <= res_lo_q;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_hi   = res_hi_q;
    assign result_lo   = res_lo_q;
    assign div_by_zero = dbz_q;
    assign alu_a       = alu_a_s;
    assign alu_b       = alu_b_s;
    assign alu_control = alu_ctrl_s;

endmodule
